// File: rtl/sun_pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// sun_pll_lock_ctrl
//
// Power-up sequencer and frequency lock detector for SUN_PLL. The block runs
// entirely on the reference clock. It raises PWRUP_1V8, waits a settle time,
// and then counts both edges of the prescaled feedback clock FB_DIV in
// fixed-length measurement windows. LOCKED is reported after LOCK_WIN
// consecutive in-tolerance windows. FAIL is reported after TIMEOUT_WIN bad
// windows without lock.
//
// Optional feature macro: SUN_PLL_LOCK_AUTORETRY_EN
//   When defined, FAIL keeps PWRUP_1V8 low for SETTLE_CYC cycles and then
//   re-enters power-up automatically. The 4th failure is sticky until EN=0.
//   When undefined, FAIL is terminal until EN=0.
//
// Ports
//   CK_REF     in   reference clock, the only clock of this block
//   RST        in   synchronous reset, active-high, has priority over EN
//   EN         in   PLL enable request (CK_REF domain)
//   FB_DIV     in   prescaled feedback clock, asynchronous to CK_REF
//   PWRUP_1V8  out  PLL power-up (registered)
//   LOCKED     out  PLL frequency locked (registered)
//   FAIL       out  lock timeout (registered)
// -----------------------------------------------------------------------------
module sun_pll_lock_ctrl #(
   parameter int SETTLE_CYC  = 256,
   parameter int WIN_CYC     = 512,
   parameter int FB_PRESCALE = 16,
   parameter int TOL         = 2,
   parameter int LOCK_WIN    = 4,
   parameter int TIMEOUT_WIN = 64
) (
   input  logic CK_REF,
   input  logic RST,
   input  logic EN,
   input  logic FB_DIV,
   output logic PWRUP_1V8,
   output logic LOCKED,
   output logic FAIL
);

   // Expected edge count per window (both edges of FB_DIV are counted).
   localparam int EXP_EDGES = 2 * WIN_CYC / FB_PRESCALE;
   localparam int SAT_EDGES = 2 * EXP_EDGES;
   localparam int LO_EDGES  = (EXP_EDGES > TOL) ? EXP_EDGES - TOL : 0;
   localparam int HI_EDGES  = (EXP_EDGES + TOL < SAT_EDGES) ? EXP_EDGES + TOL : SAT_EDGES;

   localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
   localparam int WIN_W    = $clog2(WIN_CYC + 1);
   localparam int EDGE_W   = $clog2(SAT_EDGES + 1);
   localparam int GOOD_W   = $clog2(LOCK_WIN + 1);
   localparam int TMO_W    = $clog2(TIMEOUT_WIN + 1);

   typedef enum logic [2:0] {
      ST_OFF,
      ST_PWRUP,
      ST_MEASURE,
      ST_LOCKED,
      ST_FAIL
   } state_t;

   state_t state, state_nxt;

   logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
   logic [WIN_W-1:0]    win_cnt, win_nxt;
   logic [EDGE_W-1:0]   edge_cnt, edge_nxt;
   logic [GOOD_W-1:0]   good_run, good_nxt;
   logic [TMO_W-1:0]    timeout_cnt, timeout_nxt;

   logic pwrup_nxt, locked_nxt, fail_nxt;

`ifdef SUN_PLL_LOCK_AUTORETRY_EN
   logic [1:0] retry_cnt, retry_nxt;
   logic       fail_hold, fail_hold_nxt;
`endif

   // --------------------------------------------------------------------------
   // FB_DIV synchronizer and edge detector. A level change on FB_DIV shows up
   // as a one-cycle edge pulse that is counted on the 3rd CK_REF edge.
   // --------------------------------------------------------------------------
   logic fb_meta, fb_sync, fb_last;
   logic fb_edge;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the values from before the clock edge.
   always_ff @(posedge CK_REF) begin
      if (RST) begin
         fb_meta <= 1'b0;
         fb_sync <= 1'b0;
         fb_last <= 1'b0;
      end else begin
         fb_meta <= FB_DIV;
         fb_sync <= fb_meta;
         fb_last <= fb_sync;
      end
   end

   assign fb_edge = fb_sync ^ fb_last;

   // --------------------------------------------------------------------------
   // Window evaluation. The edge seen in the last cycle of a window belongs to
   // that window, so the verdict uses the count including the current edge.
   // --------------------------------------------------------------------------
   logic              win_last;
   logic [EDGE_W-1:0] win_total;
   logic              win_good;
   logic [GOOD_W-1:0] good_inc;
   logic [TMO_W-1:0]  timeout_inc;

   assign win_last    = (win_cnt == WIN_W'(WIN_CYC - 1));
   assign win_total   = (edge_cnt == EDGE_W'(SAT_EDGES)) ? edge_cnt
                                                         : edge_cnt + EDGE_W'(fb_edge);
   assign win_good    = (win_total >= EDGE_W'(LO_EDGES)) && (win_total <= EDGE_W'(HI_EDGES));
   assign good_inc    = good_run + GOOD_W'(1);
   assign timeout_inc = timeout_cnt + TMO_W'(1);

   // --------------------------------------------------------------------------
   // Next-state and counter logic.
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_nxt   = state;
      settle_nxt  = settle_cnt;
      win_nxt     = win_cnt;
      edge_nxt    = edge_cnt;
      good_nxt    = good_run;
      timeout_nxt = timeout_cnt;
`ifdef SUN_PLL_LOCK_AUTORETRY_EN
      retry_nxt     = retry_cnt;
      fail_hold_nxt = fail_hold;
`endif

      if (!EN) begin
         // Dropping EN wins over any window verdict in the same cycle.
         state_nxt   = ST_OFF;
         settle_nxt  = '0;
         win_nxt     = '0;
         edge_nxt    = '0;
         good_nxt    = '0;
         timeout_nxt = '0;
`ifdef SUN_PLL_LOCK_AUTORETRY_EN
         retry_nxt     = '0;
         fail_hold_nxt = 1'b0;
`endif
      end else begin
         case (state)
            ST_OFF: begin
               state_nxt  = ST_PWRUP;
               settle_nxt = '0;
            end

            ST_PWRUP: begin
               if (settle_cnt == SETTLE_W'(SETTLE_CYC - 1)) begin
                  state_nxt   = ST_MEASURE;
                  settle_nxt  = '0;
                  win_nxt     = '0;
                  edge_nxt    = '0;
                  good_nxt    = '0;
                  timeout_nxt = '0;
               end else begin
                  settle_nxt = settle_cnt + SETTLE_W'(1);
               end
            end

            ST_MEASURE, ST_LOCKED: begin
               if (win_last) begin
                  // Window counter wraps; the next window's first-cycle edge
                  // is added on top of zero.
                  win_nxt  = '0;
                  edge_nxt = '0;
                  if (state == ST_MEASURE) begin
                     if (win_good) begin
                        good_nxt = good_inc;
                        if (good_inc == GOOD_W'(LOCK_WIN)) begin
                           state_nxt = ST_LOCKED;
                        end
                     end else begin
                        good_nxt    = '0;
                        timeout_nxt = timeout_inc;
                        if (timeout_inc == TMO_W'(TIMEOUT_WIN)) begin
                           state_nxt  = ST_FAIL;
                           settle_nxt = '0;
`ifdef SUN_PLL_LOCK_AUTORETRY_EN
                           // Entries 1..3 retry; the 4th entry is sticky.
                           fail_hold_nxt = (retry_cnt == 2'd3);
                           if (retry_cnt != 2'd3) begin
                              retry_nxt = retry_cnt + 2'd1;
                           end
`endif
                        end
                     end
                  end else if (!win_good) begin
                     // Loss of lock: restart the lock search from scratch.
                     state_nxt   = ST_MEASURE;
                     good_nxt    = '0;
                     timeout_nxt = '0;
                  end
               end else begin
                  win_nxt  = win_cnt + WIN_W'(1);
                  edge_nxt = win_total;
               end
            end

            ST_FAIL: begin
`ifdef SUN_PLL_LOCK_AUTORETRY_EN
               if (!fail_hold) begin
                  if (settle_cnt == SETTLE_W'(SETTLE_CYC - 1)) begin
                     state_nxt  = ST_PWRUP;
                     settle_nxt = '0;
                  end else begin
                     settle_nxt = settle_cnt + SETTLE_W'(1);
                  end
               end
`else
               state_nxt = ST_FAIL;
`endif
            end

            default: begin
               state_nxt = ST_OFF;
            end
         endcase
      end

      // Outputs are registered copies decoded from the next state, so each
      // one changes on the same edge as the state it reflects.
      pwrup_nxt  = (state_nxt == ST_PWRUP) || (state_nxt == ST_MEASURE) ||
                   (state_nxt == ST_LOCKED);
      locked_nxt = (state_nxt == ST_LOCKED);
      fail_nxt   = (state_nxt == ST_FAIL);
   end

   // --------------------------------------------------------------------------
   // State, counter and output registers.
   // --------------------------------------------------------------------------
   always_ff @(posedge CK_REF) begin
      if (RST) begin
         state       <= ST_OFF;
         settle_cnt  <= '0;
         win_cnt     <= '0;
         edge_cnt    <= '0;
         good_run    <= '0;
         timeout_cnt <= '0;
         PWRUP_1V8   <= 1'b0;
         LOCKED      <= 1'b0;
         FAIL        <= 1'b0;
      end else begin
         state       <= state_nxt;
         settle_cnt  <= settle_nxt;
         win_cnt     <= win_nxt;
         edge_cnt    <= edge_nxt;
         good_run    <= good_nxt;
         timeout_cnt <= timeout_nxt;
         PWRUP_1V8   <= pwrup_nxt;
         LOCKED      <= locked_nxt;
         FAIL        <= fail_nxt;
      end
   end

`ifdef SUN_PLL_LOCK_AUTORETRY_EN
   always_ff @(posedge CK_REF) begin
      if (RST) begin
         retry_cnt <= '0;
         fail_hold <= 1'b0;
      end else begin
         retry_cnt <= retry_nxt;
         fail_hold <= fail_hold_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_sun_pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sun_pll_lock_ctrl
//
// Bench for sun_pll_lock_ctrl (default build). FB_DIV is produced by a rate
// generator that places exactly `rate` level changes in any 512 consecutive
// cycles. The reference model works from absolute cycle numbers: it records
// the FB_DIV level seen at every clock edge, derives per-window edge totals
// from that history and applies the lock/timeout rules window by window.
// -----------------------------------------------------------------------------
module tb_sun_pll_lock_ctrl;

   localparam int SETTLE  = 256;
   localparam int WIN     = 512;
   localparam int EXP     = 64;
   localparam int TOL     = 2;
   localparam int LOCKN   = 4;
   localparam int TMO     = 64;
   localparam int MAX_CYC = 100000;

   logic CK_REF = 1'b0;
   logic RST;
   logic EN;
   logic FB_DIV;
   logic PWRUP_1V8;
   logic LOCKED;
   logic FAIL;

   sun_pll_lock_ctrl dut (
      .CK_REF    (CK_REF),
      .RST       (RST),
      .EN        (EN),
      .FB_DIV    (FB_DIV),
      .PWRUP_1V8 (PWRUP_1V8),
      .LOCKED    (LOCKED),
      .FAIL      (FAIL)
   );

   always #5 CK_REF = ~CK_REF;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // FB_DIV generator state
   int   rate = 64;
   int   acc  = 0;
   logic fb_drv = 1'b0;

   // Reference model state
   logic       fb_hist [0:MAX_CYC-1];
   bit         m_run, m_lock, m_fail;
   int         m_ek;
   int         m_edges, m_good, m_bad;
   logic [2:0] m_out;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp_v, cyc);
      end
   endtask

   function automatic logic [2:0] outs();
      return {PWRUP_1V8, LOCKED, FAIL};
   endfunction

   // One model step for the clock edge `cyc`, given the inputs sampled there.
   task automatic model_step(input bit en_s, input bit rst_s);
      int rel;
      int total;
      bit good;
      if (rst_s || !en_s) begin
         m_run  = 0;
         m_lock = 0;
         m_fail = 0;
      end else if (!m_run) begin
         m_run   = 1;
         m_ek    = cyc;
         m_lock  = 0;
         m_fail  = 0;
         m_edges = 0;
         m_good  = 0;
         m_bad   = 0;
      end else if (!m_fail) begin
         rel = cyc - m_ek;
         if (rel > SETTLE) begin
            // A level change first seen at edge j is counted at edge j+2.
            if (fb_hist[cyc-2] !== fb_hist[cyc-3]) m_edges++;
            if ((rel - SETTLE) % WIN == 0) begin
               total = (m_edges > 2*EXP) ? 2*EXP : m_edges;
               good  = (total >= EXP - TOL) && (total <= EXP + TOL);
               if (m_lock) begin
                  if (!good) begin
                     m_lock = 0;
                     m_good = 0;
                     m_bad  = 0;
                  end
               end else if (good) begin
                  m_good++;
                  if (m_good == LOCKN) m_lock = 1;
               end else begin
                  m_good = 0;
                  m_bad++;
                  if (m_bad == TMO) m_fail = 1;
               end
               m_edges = 0;
            end
         end
      end
      m_out = {m_run && !m_fail, m_lock, m_fail};
   endtask

   task automatic tick();
      @(posedge CK_REF);
      cyc++;
      if (cyc >= MAX_CYC) begin
         $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAX_CYC);
         $fatal(1, "cycle budget exhausted");
      end
      fb_hist[cyc] = FB_DIV;
      model_step(EN, RST);
      #1;
      check("outs", {29'd0, outs()}, {29'd0, m_out});
      acc += rate;
      if (acc >= WIN) begin
         acc -= WIN;
         fb_drv = ~fb_drv;
      end
      FB_DIV = fb_drv;
   endtask

   // Ticks until the chosen output (0: LOCKED, 1: FAIL) reaches `level`;
   // checks the number of ticks taken against `exp_n`.
   task automatic wait_out(input string tag, input int which, input logic level,
                           input int budget, input int exp_n);
      int   n;
      logic hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < budget) begin
         tick();
         n++;
         hit = ((which == 0) ? LOCKED : FAIL) === level;
      end
      check(tag, hit ? n : -1, exp_n);
   endtask

   task automatic restart(input int new_rate);
      EN = 1'b0;
      repeat (4) tick();
      rate = new_rate;
      EN   = 1'b1;
   endtask

   initial begin
      int n;
      int len;
      int r;

      RST    = 1'b1;
      EN     = 1'b0;
      FB_DIV = 1'b0;
      acc    = $urandom_range(0, WIN - 1);
      rate   = 64;

      // Reset and idle
      repeat (3) tick();
      check("reset_state", {29'd0, outs()}, 32'd0);
      RST = 1'b0;
      repeat (1000) tick();
      check("idle_state", {29'd0, outs()}, 32'd0);

      // Nominal lock: 1 + settle + 4 windows
      EN = 1'b1;
      wait_out("lock_nominal", 0, 1'b1, 3000, 1 + SETTLE + LOCKN*WIN);

      // Loss of lock and re-lock
      repeat (700) tick();
      rate = 0;
      n = 0;
      while (LOCKED === 1'b1 && n < 1200) begin
         tick();
         n++;
      end
      check("lock_lost", {31'd0, LOCKED}, 32'd0);
      rate = 64;
      wait_out("relock", 0, 1'b1, 3000, LOCKN*WIN);

      // EN drop at window cycle 300, then full restart
      n = 0;
      while (((cyc - m_ek - SETTLE) % WIN) != 300 && n < 600) begin
         tick();
         n++;
      end
      EN = 1'b0;
      tick();
      check("en_drop", {29'd0, outs()}, 32'd0);
      repeat (20) tick();
      EN = 1'b1;
      wait_out("lock_after_en", 0, 1'b1, 3000, 1 + SETTLE + LOCKN*WIN);

      // RST mid-measure with EN held high
      repeat (1000) tick();
      RST = 1'b1;
      tick();
      check("rst_mid", {29'd0, outs()}, 32'd0);
      tick();
      RST = 1'b0;
      wait_out("lock_after_rst", 0, 1'b1, 3000, 1 + SETTLE + LOCKN*WIN);

      // EN falls exactly on the edge that would declare lock
      restart(64);
      repeat (SETTLE + LOCKN*WIN) tick();
      EN = 1'b0;
      tick();
      check("en_vs_eval", {29'd0, outs()}, 32'd0);
      repeat (3) tick();
      check("en_vs_eval_hold", {29'd0, outs()}, 32'd0);

      // Tolerance boundaries
      restart(66);
      wait_out("lock_66", 0, 1'b1, 3000, 1 + SETTLE + LOCKN*WIN);
      restart(62);
      wait_out("lock_62", 0, 1'b1, 3000, 1 + SETTLE + LOCKN*WIN);
      restart(61);
      repeat (2400) tick();
      check("nolock_61", {31'd0, LOCKED}, 32'd0);

      // Timeout and sticky FAIL
      restart(67);
      wait_out("fail_67", 1, 1'b1, 34000, 1 + SETTLE + TMO*WIN);
      rate = 64;
      repeat (2000) tick();
      check("fail_sticky", {29'd0, outs()}, 32'd1);
      EN = 1'b0;
      tick();
      check("fail_clear", {29'd0, outs()}, 32'd0);

      // Randomized traffic
      EN  = 1'b1;
      len = 0;
      while (len < 12000) begin
         r = $urandom_range(0, 9);
         if (r == 0)      rate = 0;
         else if (r == 1) rate = $urandom_range(100, 200);
         else             rate = $urandom_range(58, 70);
         EN  = ($urandom_range(0, 7) != 0);
         RST = ($urandom_range(0, 31) == 0);
         n   = $urandom_range(50, 1500);
         if (RST) begin
            tick();
            RST = 1'b0;
            n   = n - 1;
         end
         repeat (n) tick();
         len += n + 1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
